// File: rtl/bch_decode_control_pkg.sv
// Shared types and helpers for the BCH Berlekamp-Massey sequencer.
//   bch_state_e : sequencer states
//   deg_width() : width of the locator degree L and the iteration counter k
package bch_decode_control_pkg;

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_LOAD = 3'd1,
        S_MSM  = 3'd2,
        S_UPD  = 3'd3,
        S_CH   = 3'd4,
        S_DONE = 3'd5
    } bch_state_e;

    // L never exceeds 2T-1, so log2(2T)+1 bits always hold it.
    function automatic int unsigned deg_width(input int unsigned t);
        return $clog2(2 * t) + 1;
    endfunction

endpackage

// File: rtl/bch_decode_control_bm_degree.sv
// Error-locator degree tracker for the inversionless Berlekamp-Massey loop.
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset
//   init       : iteration 0 (L <- drnzero ? 1 : 0)
//   upd        : locator update cycle for iteration k
//   drnzero    : discrepancy non-zero from the datapath
//   k          : current iteration index
//   l          : current degree L
//   bsel_c     : B<-C select, combinational, only during upd
module bch_decode_control_bm_degree
    import bch_decode_control_pkg::*;
#(
    parameter int unsigned T = 3
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      init,
    input  logic                      upd,
    input  logic                      drnzero,
    input  logic [deg_width(T)-1:0]   k,
    output logic [deg_width(T)-1:0]   l,
    output logic                      bsel_c
);

    localparam int unsigned LW = deg_width(T);

    logic le_k;

    // Length change happens only when the discrepancy is non-zero and L <= k.
    assign le_k   = (l <= k);
    assign bsel_c = upd && drnzero && le_k;

    // L register: 2k+1-L never wraps because L <= k whenever it is taken.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            l <= '0;
        end else if (init) begin
            l <= drnzero ? LW'(1) : '0;
        end else if (bsel_c) begin
            l <= (k << 1) + LW'(1) - l;
        end
    end

endmodule

// File: rtl/bch_decode_control.sv
// Sequencer for the parallel inversionless Berlekamp-Massey datapath.
// Accepts a syndrome set, steps the datapath through T iterations and hands
// the locator to the Chien search with its degree and an uncorrectable flag.
// Ports:
//   clk, rst_n           : clock, asynchronous active-low reset
//   syn_valid/syn_ready  : syndrome set handshake
//   drnzero              : discrepancy non-zero (sampled in LOAD and UPD only)
//   synpe, msmpe, snce   : datapath init, discrepancy load, locator update
//   bsel                 : B<-C select (combinational, UPD only)
//   chpe                 : Chien register load
//   out_valid/out_ready  : result handshake towards the Chien search
//   err_deg, uncorr      : final degree L and (L > T)
module bch_decode_control
    import bch_decode_control_pkg::*;
#(
    parameter int unsigned M = 4,
    parameter int unsigned T = 3
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      syn_valid,
    output logic                      syn_ready,
    input  logic                      drnzero,
    output logic                      synpe,
    output logic                      msmpe,
    output logic                      snce,
    output logic                      bsel,
    output logic                      chpe,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [deg_width(T)-1:0]   err_deg,
    output logic                      uncorr
);

    localparam int unsigned LW = deg_width(T);

    // Symbol width is carried for the datapath only; reject meaningless values.
    if (M == 0 || T == 0) begin : g_bad_params
        $error("bch_decode_control: M and T must both be at least 1");
    end

    bch_state_e      state;
    bch_state_e      state_d;
    logic [LW-1:0]   k;
    logic [LW-1:0]   l;
    logic            last_k;
    logic            bsel_c;

    assign last_k = (k == LW'(T - 1));

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_d;
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = state;
        unique case (state)
            S_IDLE: if (syn_valid) state_d = S_LOAD;
            S_LOAD: state_d = (T > 1) ? S_MSM : S_CH;
            S_MSM:  state_d = S_UPD;
            S_UPD:  state_d = last_k ? S_CH : S_MSM;
            S_CH:   state_d = S_DONE;
            S_DONE: begin
                // Back-to-back: a waiting syndrome set skips the idle cycle.
                if (out_ready) state_d = syn_valid ? S_LOAD : S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Strobes are registered decodes of the next state, so they are glitch-free
    // and drop to zero as soon as reset asserts.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            synpe     <= 1'b0;
            msmpe     <= 1'b0;
            snce      <= 1'b0;
            chpe      <= 1'b0;
            out_valid <= 1'b0;
            k         <= '0;
            err_deg   <= '0;
            uncorr    <= 1'b0;
        end else begin
            synpe     <= (state_d == S_LOAD);
            msmpe     <= (state_d == S_MSM);
            snce      <= (state_d == S_UPD);
            chpe      <= (state_d == S_CH);
            out_valid <= (state_d == S_DONE);
            if (state == S_LOAD) begin
                k <= LW'(1);
            end else if (state == S_UPD && !last_k) begin
                k <= k + LW'(1);
            end
            // Capture once on the way into DONE; held stable until the next CH.
            if (state == S_CH) begin
                err_deg <= l;
                uncorr  <= (l > LW'(T));
            end
        end
    end

    // synpe/snce equal "state is LOAD/UPD", so they double as the tracker enables.
    bch_decode_control_bm_degree #(
        .T (T)
    ) u_degree (
        .clk     (clk),
        .rst_n   (rst_n),
        .init    (synpe),
        .upd     (snce),
        .drnzero (drnzero),
        .k       (k),
        .l       (l),
        .bsel_c  (bsel_c)
    );

    assign bsel      = bsel_c;
    assign syn_ready = (state == S_IDLE) || ((state == S_DONE) && out_ready);

endmodule

// File: tb/tb_bch_decode_control.sv
// Scoreboard bench for bch_decode_control: random syndrome sets on a T=3
// instance checked cycle by cycle against a degree model, plus directed runs
// on a T=1 instance.
module tb_bch_decode_control;

    localparam int T     = 3;
    localparam int DW    = 4;     // err_deg width for T=3
    localparam int DW1   = 2;     // err_deg width for T=1
    localparam int NTX   = 40;
    localparam int LIMIT = 3000;

    typedef struct {
        int             acc;      // cycle the syndrome set was accepted
        logic [T-1:0]   bsel;     // expected bsel per iteration k (bit 0 unused)
        logic [DW-1:0]  deg;
        logic           unc;
    } txn_t;

    logic clk = 1'b0;
    logic rst_n;
    logic syn_valid, syn_ready, drnzero, out_ready;
    logic synpe, msmpe, snce, bsel, chpe, out_valid, uncorr;
    logic [DW-1:0] err_deg;

    logic syn_valid1, syn_ready1, drnzero1, out_ready1;
    logic synpe1, msmpe1, snce1, bsel1, chpe1, out_valid1, uncorr1;
    logic [DW1-1:0] err_deg1;

    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;
    int   n_done = 0;
    txn_t exp_q[$];

    int           cur_acc;
    logic [T-1:0] cur_d;
    logic [T-1:0] pend_d;
    bit           pend;
    int           ntx;
    bit           rst_done;
    int           rst_cnt;
    bit           mon_en;
    logic [T-1:0] dir_d [3] = '{3'b011, 3'b000, 3'b101};

    bch_decode_control #(.M(4), .T(T)) dut (
        .clk(clk), .rst_n(rst_n), .syn_valid(syn_valid), .syn_ready(syn_ready),
        .drnzero(drnzero), .synpe(synpe), .msmpe(msmpe), .snce(snce), .bsel(bsel),
        .chpe(chpe), .out_valid(out_valid), .out_ready(out_ready),
        .err_deg(err_deg), .uncorr(uncorr)
    );

    bch_decode_control #(.M(4), .T(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .syn_valid(syn_valid1), .syn_ready(syn_ready1),
        .drnzero(drnzero1), .synpe(synpe1), .msmpe(msmpe1), .snce(snce1), .bsel(bsel1),
        .chpe(chpe1), .out_valid(out_valid1), .out_ready(out_ready1),
        .err_deg(err_deg1), .uncorr(uncorr1)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // Berlekamp-Massey degree rule: d[0] is the LOAD discrepancy, d[k] the one of iteration k.
    function automatic txn_t model(input logic [T-1:0] d, input int acc);
        txn_t t;
        int   deg;
        t.acc  = acc;
        t.bsel = '0;
        deg    = d[0] ? 1 : 0;
        for (int kk = 1; kk < T; kk++) begin
            if (d[kk] && deg <= kk) begin
                t.bsel[kk] = 1'b1;
                deg        = 2 * kk + 1 - deg;
            end
        end
        t.deg = DW'(deg);
        t.unc = (deg > T);
        return t;
    endfunction

    // One stimulus cycle on the T=3 instance.
    task automatic step();
        int o;
        @(negedge clk);
        if (rst_cnt > 0) begin
            rst_cnt--;
            if (rst_cnt == 0) rst_n = 1'b1;
        end
        o = cyc - cur_acc;
        if (o == 1)                                      drnzero = cur_d[0];
        else if (o >= 3 && o <= 2*T-1 && (o % 2) == 1)   drnzero = cur_d[(o-1)/2];
        else                                             drnzero = 1'($urandom);
        out_ready = ($urandom_range(0, 2) != 0);
        if (!pend && ntx < NTX) begin
            pend_d = (ntx < 3) ? dir_d[ntx] : T'($urandom);
            pend   = 1'b1;
            ntx++;
        end
        if (!pend)           syn_valid = 1'b0;
        else if (!syn_valid) syn_valid = ($urandom_range(0, 3) != 0);
        // Reset in the middle of UPD k=1 of a later transaction.
        if (!rst_done && rst_n && ntx >= 8 && o == 3) begin
            rst_n    = 1'b0;
            rst_done = 1'b1;
            rst_cnt  = 2;
            #1;
            chk("async_rst_strobes", {synpe, msmpe, snce, bsel, chpe, out_valid}, 0);
            chk("async_rst_deg", {uncorr, err_deg}, 0);
            chk("async_rst_ready", syn_ready, 1);
            exp_q.delete();
            cur_acc = -1000;
            return;
        end
        #1;
        if (rst_n && syn_valid && syn_ready) begin
            exp_q.push_back(model(pend_d, cyc));
            cur_acc = cyc;
            cur_d   = pend_d;
            pend    = 1'b0;
        end
    endtask

    // One monitor cycle: expected strobes follow from the cycle offset since acceptance.
    task automatic mon_cycle();
        logic [5:0] es;
        logic       er;
        int         o;
        txn_t       tr;
        es = '0;
        er = 1'b1;
        if (exp_q.size() != 0) begin
            tr = exp_q[0];
            o  = cyc - tr.acc;
            if (o == 1)                      es = 6'b100000;
            else if (o >= 2 && o <= 2*T-1)   es = ((o % 2) == 0) ? 6'b010000
                                                  : {3'b001, tr.bsel[(o-1)/2], 2'b00};
            else if (o == 2*T)               es = 6'b000010;
            else if (o > 2*T)                es = 6'b000001;
            if (o > 2*T)     er = out_ready;
            else if (o > 0)  er = 1'b0;
        end
        chk("strobes", {synpe, msmpe, snce, bsel, chpe, out_valid}, es);
        chk("syn_ready", syn_ready, er);
        chk("strobe_excl", ($countones({synpe, msmpe, snce, chpe, out_valid}) <= 1), 1);
        if (out_valid && exp_q.size() != 0) begin
            chk("err_deg", err_deg, exp_q[0].deg);
            chk("uncorr", uncorr, exp_q[0].unc);
            if (out_ready) begin
                void'(exp_q.pop_front());
                n_done++;
            end
        end
    endtask

    // Directed run on the T=1 instance: synpe at 1, chpe at 2, out_valid at 3.
    task automatic t1_run(input logic d0);
        @(negedge clk);
        syn_valid1 = 1'b1; drnzero1 = ~d0; out_ready1 = 1'b0;
        #1 chk("t1_accept_ready", syn_ready1, 1);
        @(negedge clk);
        syn_valid1 = 1'b0; drnzero1 = d0;
        #1 chk("t1_load", {synpe1, msmpe1, snce1, bsel1, chpe1, out_valid1}, 6'b100000);
        @(negedge clk);
        drnzero1 = ~d0;
        #1 chk("t1_ch", {synpe1, msmpe1, snce1, bsel1, chpe1, out_valid1}, 6'b000010);
        @(negedge clk);
        #1;
        chk("t1_done", {synpe1, msmpe1, snce1, bsel1, chpe1, out_valid1}, 6'b000001);
        chk("t1_deg", {uncorr1, err_deg1}, {1'b0, DW1'(d0)});
        chk("t1_ready_wait", syn_ready1, 0);
        out_ready1 = 1'b1;
        #1 chk("t1_ready_pass", syn_ready1, 1);
        @(negedge clk);
        out_ready1 = 1'b0;
        #1 chk("t1_idle", {synpe1, msmpe1, snce1, bsel1, chpe1, out_valid1}, 6'b000000);
    endtask

    initial begin : monitor
        forever begin
            @(negedge clk);
            #2;
            if (mon_en && rst_n) mon_cycle();
        end
    end

    initial begin : driver
        rst_n = 1'b0; syn_valid = 1'b0; drnzero = 1'b0; out_ready = 1'b0;
        syn_valid1 = 1'b0; drnzero1 = 1'b0; out_ready1 = 1'b0;
        cur_acc = -1000; cur_d = '0; pend_d = '0; pend = 1'b0; ntx = 0;
        rst_done = 1'b0; rst_cnt = 0; mon_en = 1'b0;

        repeat (2) @(negedge clk);
        #1;
        chk("reset_strobes", {synpe, msmpe, snce, bsel, chpe, out_valid}, 0);
        chk("reset_deg", {uncorr, err_deg}, 0);
        chk("reset_ready", syn_ready, 1);
        chk("reset_t1", {synpe1, msmpe1, snce1, bsel1, chpe1, out_valid1, uncorr1, err_deg1}, 0);
        @(negedge clk);
        rst_n  = 1'b1;
        mon_en = 1'b1;

        for (int i = 0; i < LIMIT; i++) begin
            if (ntx == NTX && !pend && exp_q.size() == 0) break;
            step();
        end
        chk("all_txn_drained", {ntx == NTX, !pend, exp_q.size() == 0}, 3'b111);
        chk("mid_op_reset_hit", rst_done, 1);
        chk("completed_count", n_done, NTX - 1);

        syn_valid = 1'b0;
        out_ready = 1'b0;
        t1_run(1'b1);
        t1_run(1'b0);

        repeat (2) @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
